// File: rtl/dcache_controller_if.sv
// CPU, memory and SRAM signal bundle of the data-cache controller.
// master = controller view; slave = CPU/memory/SRAM view.
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;

  modport master (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
           mem_data_i, mem_ack_i, sram_tag_i, sram_data_i, sram_hit_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o,
           mem_data_o, sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o,
           sram_data_o
  );

  modport slave (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
           mem_data_i, mem_ack_i, sram_tag_i, sram_data_i, sram_hit_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o,
           mem_data_o, sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o,
           sram_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Data-cache controller: hit path to the 2-way SRAM plus the miss FSM
// (dirty writeback, line refill, SRAM fill) that stalls the CPU until replay.
module dcache_controller (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_controller_if.master bus
);
  localparam int unsigned TAG_W  = 23;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 256;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MISS      = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_FILL      = 3'd4;

  logic [2:0]        state, state_nx;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_line;
  logic [LINE_W-1:0] refill_line;
  logic [LINE_W-1:0] merged_line;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [OFF_W-1:0]  cpu_off;

  assign cpu_tag = bus.cpu_addr_i[31:9];
  assign cpu_idx = bus.cpu_addr_i[8:5];
  assign cpu_off = bus.cpu_addr_i[4:2];

  // Hit line with the addressed word replaced by the store data.
  always_comb begin
    merged_line = bus.sram_data_i;
    merged_line[{cpu_off, 5'b00000} +: WORD_W] = bus.cpu_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      victim_tag  <= '0;
      victim_line <= '0;
      refill_line <= '0;
    end else begin
      state <= state_nx;
      if (state == S_MISS) begin
        victim_tag  <= bus.sram_tag_i[TAG_W-1:0];
        victim_line <= bus.sram_data_i;
      end
      if (state == S_REFILL && bus.mem_ack_i) begin
        refill_line <= bus.mem_data_i;
      end
    end
  end

  always_comb begin
    state_nx          = state;
    bus.cpu_data_o    = '0;
    bus.cpu_stall_o   = 1'b1;
    bus.mem_enable_o  = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_data_o    = '0;
    bus.sram_enable_o = 1'b1;
    bus.sram_write_o  = 1'b0;
    bus.sram_addr_o   = cpu_idx;
    bus.sram_tag_o    = {2'b00, cpu_tag};
    bus.sram_data_o   = '0;

    case (state)
      S_IDLE: begin
        bus.sram_enable_o = bus.cpu_req_i;
        bus.cpu_stall_o   = bus.cpu_req_i & ~bus.sram_hit_i;
        if (bus.cpu_req_i && bus.sram_hit_i) begin
          if (bus.cpu_write_i) begin
            bus.sram_write_o = 1'b1;
            bus.sram_data_o  = merged_line;
            bus.sram_tag_o   = {2'b11, cpu_tag};
          end else begin
            bus.cpu_data_o = bus.sram_data_i[{cpu_off, 5'b00000} +: WORD_W];
          end
        end else if (bus.cpu_req_i) begin
          state_nx = S_MISS;
        end
      end
      S_MISS: begin
        // Only a valid and dirty victim needs to go back to memory.
        state_nx = (bus.sram_tag_i[24] && bus.sram_tag_i[23]) ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {victim_tag, cpu_idx, 5'b00000};
        bus.mem_data_o   = victim_line;
        if (bus.mem_ack_i) state_nx = S_REFILL;
      end
      S_REFILL: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {cpu_tag, cpu_idx, 5'b00000};
        if (bus.mem_ack_i) state_nx = S_FILL;
      end
      S_FILL: begin
        bus.sram_write_o = 1'b1;
        bus.sram_data_o  = refill_line;
        bus.sram_tag_o   = {2'b10, cpu_tag};
        state_nx         = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural 2-way LRU SRAM, delayed-ack memory
// and a golden word memory feeding a load-data scoreboard.
`timescale 1ns/1ps
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_controller_if bus();
  dcache_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus.master));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat_word(input logic [31:0] a);
    return a ^ 32'h5A3C_0F00;
  endfunction

  // Off-chip memory contents: written-back lines, else an address pattern.
  logic [255:0] mem_lines [logic [26:0]];
  function automatic logic [255:0] line_rd(input logic [26:0] la);
    logic [255:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = pat_word({la, 3'(w), 2'b00});
    return l;
  endfunction

  // Golden architectural memory and the load-data scoreboard.
  logic [31:0] gold [logic [29:0]];
  logic [31:0] exp_q [$];
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a[31:2])) return gold[a[31:2]];
    return pat_word({a[31:2], 2'b00});
  endfunction

  // SRAM model: 2 ways x 16 sets, one LRU bit per set.
  logic [24:0]  s_tag  [2][16];
  logic [255:0] s_data [2][16];
  logic         lru    [16];
  logic         sram_clr;
  logic         hit, hw, vw;
  int           n_swr = 0;
  logic [24:0]  last_stag;

  always_comb begin
    hit = 1'b0;
    hw  = 1'b0;
    for (int w = 0; w < 2; w++)
      if (s_tag[w][bus.cpu_addr_i[8:5]][24] && s_tag[w][bus.cpu_addr_i[8:5]][22:0] == bus.cpu_addr_i[31:9]) begin
        hit = 1'b1;
        hw  = w[0];
      end
    vw = hit ? hw : lru[bus.cpu_addr_i[8:5]];
    bus.sram_hit_i  = hit;
    bus.sram_tag_i  = s_tag[vw][bus.cpu_addr_i[8:5]];
    bus.sram_data_i = s_data[vw][bus.cpu_addr_i[8:5]];
  end

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          s_tag[w][s]  <= '0;
          s_data[w][s] <= '0;
        end
      for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
    end else if (bus.sram_enable_o && bus.sram_write_o) begin
      s_tag[vw][bus.sram_addr_o]  <= bus.sram_tag_o;
      s_data[vw][bus.sram_addr_o] <= bus.sram_data_o;
      lru[bus.sram_addr_o]        <= ~vw;
      n_swr                       <= n_swr + 1;
      last_stag                   <= bus.sram_tag_o;
    end else if (bus.sram_enable_o && hit) begin
      lru[bus.sram_addr_o] <= ~hw;
    end
  end

  // Memory model with programmable ack delay, plus stability monitor.
  int          ack_delay = 0;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  int          n_issue = 0;
  int          stab_err = 0;
  logic        mon_pend = 1'b0;
  logic        mon_wr;
  logic [31:0] mon_addr;
  logic [31:0] last_wb_addr = '0;
  logic [31:0] last_rd_addr = '0;

  always @(negedge clk) begin
    if (mon_pend && !rst &&
        (!bus.mem_enable_o || bus.mem_addr_o != mon_addr || bus.mem_write_o != mon_wr))
      stab_err++;
    if (rst) begin
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      mem_busy       = 1'b0;
    end else if (bus.mem_ack_i) begin
      bus.mem_ack_i = 1'b0;
    end else if (bus.mem_enable_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = ack_delay;
        n_issue++;
        if (bus.mem_write_o) last_wb_addr = bus.mem_addr_o;
        else                 last_rd_addr = bus.mem_addr_o;
      end
      if (mem_cnt == 0) begin
        bus.mem_ack_i = 1'b1;
        mem_busy      = 1'b0;
        if (bus.mem_write_o) mem_lines[bus.mem_addr_o[31:5]] = bus.mem_data_o;
        else                 bus.mem_data_i = line_rd(bus.mem_addr_o[31:5]);
      end else begin
        mem_cnt--;
      end
    end
    mon_pend = bus.mem_enable_o && !bus.mem_ack_i && !rst;
    mon_addr = bus.mem_addr_o;
    mon_wr   = bus.mem_write_o;
  end

  // One CPU access, driven just after a falling edge; returns stall cycles.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int dly, output int waited);
    ack_delay       = dly;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = a;
    bus.cpu_data_i  = d;
    if (wr) gold[a[31:2]] = d;
    else    exp_q.push_back(gold_rd(a));
    waited = 0;
    #1;
    while (bus.cpu_stall_o && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.cpu_stall_o) chk("stall_timeout", 32'(bus.cpu_stall_o), 0);
    else if (!wr) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("load_data", bus.cpu_data_o, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  logic [31:0] b2b_addr [4] = '{32'h0000_0248, 32'h0001_0080, 32'h0001_00A0, 32'h0001_00C0};
  logic [31:0] dly_addr [3] = '{32'h0001_0080, 32'h0001_00A0, 32'h0001_00C0};
  int          dly_val  [3] = '{0, 1, 50};

  initial begin
    int          wt;
    int          s0;
    int          i0;
    logic [31:0] a;
    logic [26:0] la;

    rst = 1'b1;
    sram_clr = 1'b1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    repeat (2) @(negedge clk);
    sram_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_enable", 32'(bus.mem_enable_o), 0);
    chk("rst_mem_write", 32'(bus.mem_write_o), 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_data_zero", 32'(bus.mem_data_o == '0), 1);
    chk("rst_sram_write", 32'(bus.sram_write_o), 0);
    chk("rst_cpu_data", bus.cpu_data_o, 0);
    chk("rst_stall", 32'(bus.cpu_stall_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load miss, clean victim, ack after 10 cycles.
    s0 = n_swr;
    access(1'b0, 32'h0000_0248, 32'h0, 10, wt);
    chk("cold_refill_addr", last_rd_addr, 32'h0000_0240);
    chk("cold_fill_tag", 32'(last_stag), 32'h0100_0001);
    chk("cold_one_fill", n_swr - s0, 1);
    access(1'b0, 32'h0000_0248, 32'h0, 0, wt);
    chk("cold_replay_nostall", wt, 0);

    // Store hit at offset 0x1C of the same line.
    bus.cpu_req_i = 1'b1;
    bus.cpu_write_i = 1'b1;
    bus.cpu_addr_i = 32'h0000_025C;
    bus.cpu_data_i = 32'hDEAD_BEEF;
    gold[30'(32'h0000_025C >> 2)] = 32'hDEAD_BEEF;
    #1;
    chk("st_hit_sram_write", 32'(bus.sram_write_o), 1);
    chk("st_hit_word7", bus.sram_data_o[255:224], 32'hDEAD_BEEF);
    chk("st_hit_dirty", 32'(bus.sram_tag_o[24:23]), 3);
    chk("st_hit_nostall", 32'(bus.cpu_stall_o), 0);
    @(posedge clk);
    @(negedge clk);
    access(1'b0, 32'h0000_025C, 32'h0, 0, wt);
    access(1'b0, 32'h0000_0248, 32'h0, 0, wt);

    // Dirty victim tag 5 in set 3 gets written back.
    access(1'b1, 32'h0000_0A64, 32'h1234_5678, 3, wt);
    access(1'b0, 32'h0000_0C60, 32'h0, 2, wt);
    i0 = n_issue;
    access(1'b0, 32'h0000_0E60, 32'h0, 4, wt);
    chk("wb_addr", last_wb_addr, 32'h0000_0A60);
    la = 27'(32'h0000_0A60 >> 5);
    chk("wb_data_word1", mem_lines[la][63:32], 32'h1234_5678);
    chk("wb_then_refill", n_issue - i0, 2);
    chk("wb_refill_addr", last_rd_addr, 32'h0000_0E60);
    access(1'b0, 32'h0000_0A64, 32'h0, 1, wt);

    // Ack latency sweep: one SRAM write per miss.
    foreach (dly_addr[k]) begin
      s0 = n_swr;
      access(1'b0, dly_addr[k], 32'h0, dly_val[k], wt);
      chk("dly_one_fill", n_swr - s0, 1);
    end
    chk("mem_stable", stab_err, 0);

    // Reset while in REFILL abandons the transfer.
    s0 = n_swr;
    ack_delay = 30;
    bus.cpu_req_i = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i = 32'h0002_0100;
    wt = 0;
    #1;
    while (!(bus.mem_enable_o && !bus.mem_write_o) && wt < 20) begin
      @(negedge clk);
      #1;
      wt++;
    end
    chk("reach_refill", 32'(bus.mem_enable_o && !bus.mem_write_o), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_refill_mem_enable", 32'(bus.mem_enable_o), 0);
    chk("rst_refill_sram_write", 32'(bus.sram_write_o), 0);
    chk("rst_refill_stall", 32'(bus.cpu_stall_o), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_refill_nofill", n_swr - s0, 0);

    // Back-to-back load hits to four sets.
    i0 = n_issue;
    foreach (b2b_addr[k]) begin
      access(1'b0, b2b_addr[k], 32'h0, 0, wt);
      chk("b2b_nostall", wt, 0);
    end
    chk("b2b_no_mem", n_issue - i0, 0);

    // Random mix over five tags competing for four sets.
    for (int n = 0; n < 40; n++) begin
      a = {23'($urandom_range(1, 5)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 9) < 4), a, $urandom, $urandom_range(0, 5), wt);
    end
    bus.cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mem_stable_final", stab_err, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
